// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding and port indices.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic PORT_IF  = 1'b0;
   localparam logic PORT_LSU = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side signals of the shared memory port.
interface mem_port_arbiter_if #(
   parameter int WIDTH = 32
);
   logic [1:0]       req;
   logic [WIDTH-1:0] addr0;
   logic [WIDTH-1:0] addr1;
   logic [WIDTH-1:0] wdata0;
   logic [WIDTH-1:0] wdata1;
   logic [1:0]       we;
   logic [1:0]       gnt;
   logic [1:0]       rvalid;
   logic [WIDTH-1:0] rdata;
   logic             err;
   logic             sel;
   logic             mem_req;
   logic [WIDTH-1:0] mem_addr;
   logic [WIDTH-1:0] mem_wdata;
   logic             mem_we;
   logic             mem_ready;
   logic [WIDTH-1:0] mem_rdata;

   // The arbiter itself is the slave side.
   modport slave (
      input  req, addr0, addr1, wdata0, wdata1, we, mem_ready, mem_rdata,
      output gnt, rvalid, rdata, err, sel, mem_req, mem_addr, mem_wdata, mem_we
   );

   modport master (
      output req, addr0, addr1, wdata0, wdata1, we, mem_ready, mem_rdata,
      input  gnt, rvalid, rdata, err, sel, mem_req, mem_addr, mem_wdata, mem_we
   );

endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational 2-way round-robin pick: a lone requester wins, a tie goes away from last_sel.
module rr_pick2
   import mem_port_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_sel,
   output logic       winner
);

   always_comb begin
      winner = PORT_IF;
      if (req == 2'b11) begin
         winner = ~last_sel;
      end else if (req[PORT_LSU]) begin
         winner = PORT_LSU;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (port 0) and load/store (port 1) with
// round-robin arbitration and a bounded wait for mem_ready.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 16
) (
   input  logic          clk,
   input  logic          reset,
   mem_port_arbiter_if.slave bus
);

   localparam int              CNT_W    = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t           state_reg, state_next;
   logic             last_sel_reg, last_sel_next;
   logic             sel_reg, sel_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             err_reg, err_next;
   logic [WIDTH-1:0] rdata_reg, rdata_next;
   logic [WIDTH-1:0] addr_reg, addr_next;
   logic [WIDTH-1:0] wdata_reg, wdata_next;
   logic             we_reg, we_next;
   logic             winner;

   rr_pick2 u_pick (
      .req      (bus.req),
      .last_sel (last_sel_reg),
      .winner   (winner)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= IDLE;
         last_sel_reg <= PORT_LSU;
         sel_reg      <= PORT_IF;
         cnt_reg      <= '0;
         err_reg      <= 1'b0;
         rdata_reg    <= '0;
         addr_reg     <= '0;
         wdata_reg    <= '0;
         we_reg       <= 1'b0;
      end else begin
         state_reg    <= state_next;
         last_sel_reg <= last_sel_next;
         sel_reg      <= sel_next;
         cnt_reg      <= cnt_next;
         err_reg      <= err_next;
         rdata_reg    <= rdata_next;
         addr_reg     <= addr_next;
         wdata_reg    <= wdata_next;
         we_reg       <= we_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      last_sel_next = last_sel_reg;
      sel_next      = sel_reg;
      cnt_next      = cnt_reg;
      err_next      = err_reg;
      rdata_next    = rdata_reg;
      addr_next     = addr_reg;
      wdata_next    = wdata_reg;
      we_next       = we_reg;

      case (state_reg)
         IDLE: begin
            if (|bus.req) begin
               sel_next   = winner;
               addr_next  = (winner == PORT_LSU) ? bus.addr1 : bus.addr0;
               wdata_next = (winner == PORT_LSU) ? bus.wdata1 : bus.wdata0;
               we_next    = bus.we[winner];
               cnt_next   = '0;
               err_next   = 1'b0;
               state_next = ACCESS;
            end
         end
         ACCESS: begin
            // A ready arriving in the final allowed cycle still completes normally.
            if (bus.mem_ready) begin
               rdata_next = bus.mem_rdata;
               err_next   = 1'b0;
               state_next = RESP;
            end else if (cnt_reg == CNT_LAST) begin
               rdata_next = '0;
               err_next   = 1'b1;
               state_next = RESP;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         RESP: begin
            last_sel_next = sel_reg;
            state_next    = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // The counter is only zero during the first ACCESS cycle, which is when gnt pulses.
   for (genvar gi = 0; gi < 2; gi++) begin : g_port
      assign bus.gnt[gi]    = (state_reg == ACCESS) && (cnt_reg == '0) && (sel_reg == 1'(gi));
      assign bus.rvalid[gi] = (state_reg == RESP) && (sel_reg == 1'(gi));
   end

   assign bus.mem_req   = (state_reg == ACCESS);
   assign bus.err       = (state_reg == RESP) && err_reg;
   assign bus.rdata     = rdata_reg;
   assign bus.sel       = sel_reg;
   assign bus.mem_addr  = addr_reg;
   assign bus.mem_wdata = wdata_reg;
   assign bus.mem_we    = we_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: fixed vector table, reset-mid-access sequence and
// randomized transactions checked against a round-robin reference model.
module tb_mem_port_arbiter;

   localparam int TIMEOUT = 4;

   typedef struct {
      logic [1:0]  req;
      logic [1:0]  we;
      logic [31:0] addr0;
      logic [31:0] addr1;
      logic [31:0] wdata0;
      logic [31:0] wdata1;
      int          delay;      // ACCESS cycle (0-based) in which mem_ready is driven
      logic [31:0] mrdata;
      logic        exp_port;
      logic [31:0] exp_addr;
      logic [31:0] exp_wdata;
      logic        exp_we;
      int          exp_cycles;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   mem_port_arbiter_if #(.WIDTH(32)) bus ();

   mem_port_arbiter #(.WIDTH(32), .TIMEOUT(TIMEOUT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Entered at a negedge while the DUT is IDLE; returns at the negedge of the following IDLE cycle.
   task automatic run_txn(input vec_t v, input string tag);
      int k;
      logic [1:0] oh;
      oh = v.exp_port ? 2'b10 : 2'b01;
      bus.req    = v.req;
      bus.we     = v.we;
      bus.addr0  = v.addr0;
      bus.addr1  = v.addr1;
      bus.wdata0 = v.wdata0;
      bus.wdata1 = v.wdata1;
      bus.mem_ready = 1'b0;
      @(negedge clk);
      check({tag, ".gnt"}, bus.gnt, oh);
      check({tag, ".mem_req"}, bus.mem_req, 1'b1);
      check({tag, ".sel"}, bus.sel, v.exp_port);
      check({tag, ".mem_wdata"}, bus.mem_wdata, v.exp_wdata);
      check({tag, ".mem_we"}, bus.mem_we, v.exp_we);
      bus.req[v.exp_port] = 1'b0;
      k = 0;
      while (bus.mem_req === 1'b1 && k < 2 * TIMEOUT) begin
         if (k > 0) check({tag, ".gnt_once"}, bus.gnt, 2'b00);
         check({tag, ".mem_addr"}, bus.mem_addr, v.exp_addr);
         check({tag, ".rvalid_busy"}, bus.rvalid, 2'b00);
         bus.mem_ready = (k == v.delay);
         bus.mem_rdata = (k == v.delay) ? v.mrdata : $urandom;
         k++;
         @(negedge clk);
      end
      bus.mem_ready = 1'b0;
      check({tag, ".access_cycles"}, k, v.exp_cycles);
      check({tag, ".rvalid"}, bus.rvalid, oh);
      check({tag, ".err"}, bus.err, v.exp_err);
      check({tag, ".rdata"}, bus.rdata, v.exp_rdata);
      check({tag, ".sel_hold"}, bus.sel, v.exp_port);
      $display("txn %s port=%0d addr=%h cycles=%0d err=%0b rdata=%h",
               tag, bus.sel, bus.mem_addr, k, bus.err, bus.rdata);
      @(negedge clk);
      check({tag, ".idle_rvalid"}, bus.rvalid, 2'b00);
      check({tag, ".idle_mem_req"}, bus.mem_req, 1'b0);
   endtask

   vec_t tbl [8];
   vec_t rv;
   logic last_port;

   initial begin
      //            req    we     addr0   addr1   wdata0  wdata1  dly mrdata        port  exp_addr exp_wd  we  cyc err exp_rdata
      tbl[0] = '{2'b11, 2'b00, 32'h200, 32'h300, 32'h11, 32'h22, 1, 32'h000000A0, 1'b0, 32'h200, 32'h11, 1'b0, 2, 1'b0, 32'h000000A0};
      tbl[1] = '{2'b11, 2'b00, 32'h200, 32'h300, 32'h11, 32'h22, 0, 32'h000000B1, 1'b1, 32'h300, 32'h22, 1'b0, 1, 1'b0, 32'h000000B1};
      tbl[2] = '{2'b01, 2'b00, 32'h100, 32'h0,   32'h0,  32'h0,  0, 32'hDEADBEEF, 1'b0, 32'h100, 32'h0,  1'b0, 1, 1'b0, 32'hDEADBEEF};
      tbl[3] = '{2'b10, 2'b10, 32'h0,   32'h20,  32'h0,  32'h55, 0, 32'h0,        1'b1, 32'h20,  32'h55, 1'b1, 1, 1'b0, 32'h0};
      tbl[4] = '{2'b01, 2'b00, 32'h40,  32'h0,   32'h0,  32'h0, 15, 32'h1234,     1'b0, 32'h40,  32'h0,  1'b0, 4, 1'b1, 32'h0};
      tbl[5] = '{2'b10, 2'b00, 32'h0,   32'h44,  32'h0,  32'h0,  3, 32'hCAFEF00D, 1'b1, 32'h44,  32'h0,  1'b0, 4, 1'b0, 32'hCAFEF00D};
      tbl[6] = '{2'b11, 2'b01, 32'h50,  32'h54,  32'h66, 32'h88, 2, 32'h77,       1'b0, 32'h50,  32'h66, 1'b1, 3, 1'b0, 32'h77};
      tbl[7] = '{2'b11, 2'b01, 32'h50,  32'h54,  32'h66, 32'h88, 0, 32'h99,       1'b1, 32'h54,  32'h88, 1'b0, 1, 1'b0, 32'h99};

      bus.req = 2'b00; bus.we = 2'b00;
      bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
      bus.mem_ready = 1'b0; bus.mem_rdata = '0;

      repeat (2) @(negedge clk);
      check("reset.gnt", bus.gnt, 2'b00);
      check("reset.rvalid", bus.rvalid, 2'b00);
      check("reset.err", bus.err, 1'b0);
      check("reset.rdata", bus.rdata, 32'h0);
      check("reset.sel", bus.sel, 1'b0);
      check("reset.mem_req", bus.mem_req, 1'b0);
      check("reset.mem_addr", bus.mem_addr, 32'h0);
      check("reset.mem_wdata", bus.mem_wdata, 32'h0);
      check("reset.mem_we", bus.mem_we, 1'b0);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         run_txn(tbl[i], $sformatf("vec%0d", i));
      end

      // Reset asserted in the middle of an access.
      bus.req = 2'b10; bus.addr1 = 32'h60; bus.we = 2'b00;
      @(negedge clk);
      check("rst_mid.mem_req_before", bus.mem_req, 1'b1);
      check("rst_mid.sel_before", bus.sel, 1'b1);
      #2;
      reset = 1'b1;
      bus.req = 2'b00;
      #1;
      check("rst_mid.mem_req", bus.mem_req, 1'b0);
      check("rst_mid.sel", bus.sel, 1'b0);
      check("rst_mid.mem_addr", bus.mem_addr, 32'h0);
      check("rst_mid.rdata", bus.rdata, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_mid.no_rvalid", bus.rvalid, 2'b00);
         check("rst_mid.no_gnt", bus.gnt, 2'b00);
      end
      $display("txn rst_mid dropped in-flight access");
      rv = '{2'b01, 2'b00, 32'h104, 32'h0, 32'h0, 32'h0, 1, 32'h13572468, 1'b0, 32'h104, 32'h0, 1'b0, 2, 1'b0, 32'h13572468};
      run_txn(rv, "post_reset");

      // Randomized traffic against the round-robin model.
      last_port = 1'b0;
      for (int i = 0; i < 40; i++) begin
         rv.req    = 2'($urandom_range(1, 3));
         rv.we     = 2'($urandom_range(0, 3));
         rv.addr0  = $urandom;
         rv.addr1  = $urandom;
         rv.wdata0 = $urandom;
         rv.wdata1 = $urandom;
         rv.delay  = $urandom_range(0, TIMEOUT + 1);
         rv.mrdata = $urandom;
         if (rv.req == 2'b11) rv.exp_port = ~last_port;
         else                 rv.exp_port = rv.req[1];
         rv.exp_addr   = rv.exp_port ? rv.addr1 : rv.addr0;
         rv.exp_wdata  = rv.exp_port ? rv.wdata1 : rv.wdata0;
         rv.exp_we     = rv.we[rv.exp_port];
         rv.exp_err    = (rv.delay >= TIMEOUT);
         rv.exp_cycles = rv.exp_err ? TIMEOUT : rv.delay + 1;
         rv.exp_rdata  = rv.exp_err ? 32'h0 : rv.mrdata;
         run_txn(rv, $sformatf("rand%0d", i));
         last_port = rv.exp_port;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
